music_sequencer: RTL and testbench

Multi-track beat sequencer that generalises the single-track beat counter into a parametrised player: it selects one of NUM_TRACKS tracks, each with its own length, and advances a beat index at a prescaled rate. It supports play, pause/resume, stop, and loop or one-shot modes. It sits between the control FSM (sensor/button commands) and the note ROM/tone generator, which index on `track` and `ibeat`.

---
 rtl/music_pkg.sv | 20 ++
 rtl/beat_prescaler.sv | 35 +++
 rtl/music_sequencer.sv | 150 +++++++++++++++
 tb/tb_music_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// ------------------------------------------------------------------
// music_pkg: shared state encoding and default track/prescale constants
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [47:0] c_LEN_LIST_DEF = {12'd1, 12'd5, 12'd8, 12'd30};
    localparam int          c_DIV_DEF      = 1;

endpackage

`default_nettype wire

// File: rtl/beat_prescaler.sv
// ------------------------------------------------------------------
// beat_prescaler: divides clk down to one tick every DIV enabled cycles
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module beat_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_CW-1:0] div_cnt_q;

    assign tick = en && !clr && (div_cnt_q == c_CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else if (clr) begin
            div_cnt_q <= '0;
        end else if (en) begin
            div_cnt_q <= tick ? '0 : div_cnt_q + c_CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/music_sequencer.sv
// ------------------------------------------------------------------
// music_sequencer: multi-track beat player with pause/resume, stop, loop
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module music_sequencer
    import music_pkg::*;
#(
    parameter int                           BEAT_W     = 12,
    parameter int                           NUM_TRACKS = 4,
    parameter int                           TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
    parameter logic [NUM_TRACKS*BEAT_W-1:0] LEN_LIST   = c_LEN_LIST_DEF,
    parameter int                           DIV        = c_DIV_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop,
    input  logic [TRK_W-1:0]  track_sel,
    output logic [BEAT_W-1:0] ibeat,
    output logic [TRK_W-1:0]  track,
    output logic              playing,
    output logic              paused,
    output logic              beat_strobe,
    output logic              done
);

    localparam logic [TRK_W:0] c_NT = (TRK_W + 1)'(NUM_TRACKS);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] ibeat_q, ibeat_d;
    logic [TRK_W-1:0]  track_q, track_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;

    logic              w_start;
    logic              w_tick;
    logic              w_en;
    logic              w_clr;
    logic [BEAT_W-1:0] w_len;
    logic [BEAT_W:0]   w_next;

    // Prescaler runs only while playing with no overriding command this cycle.
    assign w_en  = (state_q == ST_PLAY) && !stop && !pause;
    assign w_clr = stop || w_start;

    beat_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        w_len = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (track_q == TRK_W'(i)) begin
                w_len = LEN_LIST[i*BEAT_W +: BEAT_W];
            end
        end
        if (w_len == '0) begin
            w_len = BEAT_W'(1);
        end
    end

    // One extra bit keeps the end-of-track compare safe at the maximum index.
    assign w_next = {1'b0, ibeat_q} + (BEAT_W + 1)'(1);

    always_comb begin
        state_d  = state_q;
        ibeat_d  = ibeat_q;
        track_d  = track_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        w_start  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            ibeat_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!pause && play && ({1'b0, track_sel} < c_NT)) begin
                        w_start = 1'b1;
                        track_d = track_sel;
                        ibeat_d = '0;
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (w_tick) begin
                        if (w_next < {1'b0, w_len}) begin
                            ibeat_d  = w_next[BEAT_W-1:0];
                            strobe_d = 1'b1;
                        end else if (loop) begin
                            ibeat_d  = '0;
                            strobe_d = 1'b1;
                        end else begin
                            ibeat_d = '0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause && play) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ibeat_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ibeat_q  <= '0;
            track_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ibeat_q  <= ibeat_d;
            track_q  <= track_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign ibeat       = ibeat_q;
    assign track       = track_q;
    assign playing     = (state_q == ST_PLAY);
    assign paused      = (state_q == ST_PAUSE);
    assign beat_strobe = strobe_q;
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_music_sequencer.sv
// ------------------------------------------------------------------
// tb_music_sequencer: directed vector table plus hand-written corner sequences
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_music_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play, pause, stop, loop;
    logic [1:0]  track_sel;
    logic [11:0] ibeat;
    logic [1:0]  track;
    logic        playing, paused, beat_strobe, done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        pl, pa, sp, lp;
        logic [1:0]  ts;
        logic [11:0] eib;
        logic        epl, epa, est, edn;
        logic [1:0]  etr;
    } vec_t;

    vec_t vecs[$];

    music_sequencer #(
        .BEAT_W     (12),
        .NUM_TRACKS (4),
        .LEN_LIST   ({12'd1, 12'd5, 12'd8, 12'd30}),
        .DIV        (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .pause       (pause),
        .stop        (stop),
        .loop        (loop),
        .track_sel   (track_sel),
        .ibeat       (ibeat),
        .track       (track),
        .playing     (playing),
        .paused      (paused),
        .beat_strobe (beat_strobe),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        play = 0; pause = 0; stop = 0;
    endtask

    task automatic chk_all(input string tag, input logic [11:0] eib, input logic epl,
                           input logic epa, input logic est, input logic edn, input logic [1:0] etr);
        chk({tag, ".ibeat"},   ibeat,       eib);
        chk({tag, ".playing"}, playing,     epl);
        chk({tag, ".paused"},  paused,      epa);
        chk({tag, ".strobe"},  beat_strobe, est);
        chk({tag, ".done"},    done,        edn);
        chk({tag, ".track"},   track,       etr);
    endtask

    function automatic void add(logic pl, logic pa, logic sp, logic lp, logic [1:0] ts,
                                logic [11:0] eib, logic epl, logic epa, logic est, logic edn,
                                logic [1:0] etr);
        vec_t v;
        v.pl = pl; v.pa = pa; v.sp = sp; v.lp = lp; v.ts = ts;
        v.eib = eib; v.epl = epl; v.epa = epa; v.est = est; v.edn = edn; v.etr = etr;
        vecs.push_back(v);
    endfunction

    initial begin
        int strobes;
        // Track 2 (length 5), one-shot: beat every 3 cycles, done after ibeat 4.
        add(0,0,0,0,0,  0,0,0,0,0,0);
        add(1,0,0,0,2,  0,1,0,0,0,2);
        add(0,0,0,0,0,  0,1,0,0,0,2);
        add(0,0,0,0,0,  0,1,0,0,0,2);
        add(0,0,0,0,0,  1,1,0,1,0,2);
        add(0,0,0,0,0,  1,1,0,0,0,2);
        add(1,0,0,0,1,  1,1,0,0,0,2);
        add(0,0,0,0,0,  2,1,0,1,0,2);
        add(0,0,0,0,0,  2,1,0,0,0,2);
        add(0,0,0,0,0,  2,1,0,0,0,2);
        add(0,0,0,0,0,  3,1,0,1,0,2);
        add(0,0,0,0,0,  3,1,0,0,0,2);
        add(0,0,0,0,0,  3,1,0,0,0,2);
        add(0,0,0,0,0,  4,1,0,1,0,2);
        add(0,0,0,0,0,  4,1,0,0,0,2);
        add(0,0,0,0,0,  4,1,0,0,0,2);
        add(0,0,0,0,0,  0,0,0,0,1,2);
        add(0,0,0,0,0,  0,0,0,0,0,2);
        add(0,1,0,0,0,  0,0,0,0,0,2);

        idle_in(); loop = 0; track_sel = 0;
        reset = 1;
        step(); step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 0;

        strobes = 0;
        foreach (vecs[i]) begin
            play = vecs[i].pl; pause = vecs[i].pa; stop = vecs[i].sp;
            loop = vecs[i].lp; track_sel = vecs[i].ts;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].eib, vecs[i].epl, vecs[i].epa,
                    vecs[i].est, vecs[i].edn, vecs[i].etr);
            if (beat_strobe) strobes++;
        end
        chk("s1.strobe_count", strobes, 4);
        idle_in();

        // Track 1 (length 8) looping for 30 ticks.
        loop = 1; track_sel = 1; play = 1; step(); play = 0;
        strobes = 0;
        for (int t = 1; t <= 30; t++) begin
            step(); step(); step();
            chk($sformatf("loop.t%0d.ibeat", t), ibeat, t % 8);
            chk($sformatf("loop.t%0d.done", t), done, 0);
            if (beat_strobe) strobes++;
        end
        chk("loop.strobe_count", strobes, 30);
        chk("loop.playing", playing, 1);
        stop = 1; step(); stop = 0;
        chk_all("loop.stop", 0, 0, 0, 0, 0, 1);

        // Track 0: pause at ibeat 10 with the prescaler at 1, then resume.
        track_sel = 0; play = 1; step(); play = 0;
        for (int c = 0; c < 31; c++) step();
        chk("pz.pre_ibeat", ibeat, 10);
        pause = 1; step(); pause = 0;
        chk_all("pz.enter", 10, 0, 1, 0, 0, 0);
        for (int c = 0; c < 17; c++) begin
            step();
            chk($sformatf("pz.hold%0d", c), {ibeat, paused, beat_strobe}, {12'd10, 1'b1, 1'b0});
        end
        play = 1; step(); play = 0;
        chk_all("pz.resume", 10, 1, 0, 0, 0, 0);
        step();
        chk("pz.r1.ibeat", ibeat, 10);
        step();
        chk_all("pz.r2", 11, 1, 0, 1, 0, 0);

        // Stop and pause together mid-track, then looping single-beat track 3.
        stop = 1; step(); stop = 0;
        play = 1; track_sel = 0; step(); play = 0;
        for (int c = 0; c < 18; c++) step();
        chk("sp.pre_ibeat", ibeat, 6);
        stop = 1; pause = 1; step(); idle_in();
        chk_all("sp.both", 0, 0, 0, 0, 0, 0);
        loop = 1; track_sel = 3; play = 1; step(); play = 0;
        chk_all("t3loop.start", 0, 1, 0, 0, 0, 3);
        for (int t = 0; t < 3; t++) begin
            step();
            chk($sformatf("t3loop.%0d.a", t), {ibeat, beat_strobe}, {12'd0, 1'b0});
            step();
            chk($sformatf("t3loop.%0d.b", t), {ibeat, beat_strobe}, {12'd0, 1'b0});
            step();
            chk($sformatf("t3loop.%0d.c", t), {ibeat, beat_strobe, done}, {12'd0, 1'b1, 1'b0});
        end

        // Track 3 one-shot: done after 3 cycles, ibeat never moves.
        stop = 1; step(); stop = 0;
        loop = 0; play = 1; step(); play = 0;
        chk("t3os.playing", playing, 1);
        step(); chk("t3os.c1", {ibeat, done}, {12'd0, 1'b0});
        step(); chk("t3os.c2", {ibeat, done}, {12'd0, 1'b0});
        step(); chk_all("t3os.done", 0, 0, 0, 0, 1, 3);
        step(); chk("t3os.after", {ibeat, done, beat_strobe}, {12'd0, 1'b0, 1'b0});

        // Asynchronous reset mid-beat on track 0.
        loop = 1; track_sel = 0; play = 1; step(); play = 0;
        for (int c = 0; c < 4; c++) step();
        chk("ar.pre_ibeat", ibeat, 1);
        #2 reset = 1;
        #1 chk_all("ar.async", 0, 0, 0, 0, 0, 0);
        step(); #3 reset = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("ar.post%0d", c), {ibeat, playing, beat_strobe, done}, 15'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
